// File: rtl/ctr_decryption.sv
// Streaming AES-256 CTR-mode decryptor driving an external fixed-latency forward AES core.
// Optional trailing-partial-block masking is enabled with the CTR_LASTMASK_EN macro.
module ctr_decryption #(
  parameter int AES_LATENCY = 15,
  parameter int MAX_BLOCKS  = 8,
  localparam int NB_W = $clog2(MAX_BLOCKS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [127:0]    iv,
  input  logic [255:0]    key,
  input  logic [NB_W-1:0] nblocks,
`ifdef CTR_LASTMASK_EN
  input  logic [3:0]      last_bytes,
`endif
  input  logic            ct_valid,
  output logic            ct_ready,
  input  logic [127:0]    ct_data,
  output logic            pt_valid,
  input  logic            pt_ready,
  output logic [127:0]    pt_data,
  output logic [127:0]    aes_in,
  input  logic [127:0]    aes_out,
  output logic [255:0]    aes_key,
  output logic            busy,
  output logic            done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_KS_WAIT = 3'd1,
    S_CT_WAIT = 3'd2,
    S_PT_OUT  = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

  localparam logic [5:0]      LAT_M1  = 6'(AES_LATENCY - 1);
  localparam logic [NB_W-1:0] ONE_BLK = NB_W'(1);

  state_t          state_r, state_s;
  logic [127:0]    ctr_r, ctr_s;
  logic [127:0]    ks_r, ks_s;
  logic [NB_W-1:0] remaining_r, remaining_s;
  logic [5:0]      wait_cnt_r, wait_cnt_s;
  logic            ct_ready_s, pt_valid_s, busy_s, done_s;
  logic [127:0]    pt_data_s, aes_in_s;

`ifdef CTR_LASTMASK_EN
  logic [3:0] last_r, last_s;

  // Keep the leading n bytes (MSB first); n==0 keeps the whole block.
  function automatic logic [127:0] tail_mask(input logic [3:0] n);
    if (n == 4'd0) begin
      tail_mask = {128{1'b1}};
    end else begin
      tail_mask = ~({128{1'b1}} >> {n, 3'b000});
    end
  endfunction
`endif

  assign aes_key = key;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = (nblocks != {NB_W{1'b0}}) ? S_KS_WAIT : S_FINISH;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_KS_WAIT: begin
        if (wait_cnt_r == LAT_M1) begin
          state_s = S_CT_WAIT;
        end else begin
          state_s = S_KS_WAIT;
        end
      end
      S_CT_WAIT: begin
        if (ct_valid && ct_ready) begin
          state_s = S_PT_OUT;
        end else begin
          state_s = S_CT_WAIT;
        end
      end
      S_PT_OUT: begin
        if (pt_ready) begin
          state_s = (remaining_r == ONE_BLK) ? S_FINISH : S_KS_WAIT;
        end else begin
          state_s = S_PT_OUT;
        end
      end
      S_FINISH: state_s = S_IDLE;
      default:  state_s = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values; the wait counter runs from every aes_in
  // change and saturates, so time spent stalled in PT_OUT shortens the next KS_WAIT.
  always_comb begin
    ctr_s       = ctr_r;
    ks_s        = ks_r;
    remaining_s = remaining_r;
    wait_cnt_s  = (wait_cnt_r == LAT_M1) ? wait_cnt_r : wait_cnt_r + 6'd1;
    ct_ready_s  = 1'b0;
    pt_valid_s  = pt_valid;
    pt_data_s   = pt_data;
    aes_in_s    = aes_in;
    busy_s      = (state_s != S_IDLE);
    done_s      = (state_s == S_FINISH);
`ifdef CTR_LASTMASK_EN
    last_s      = last_r;
`endif
    case (state_r)
      S_IDLE: begin
        if (start && (nblocks != {NB_W{1'b0}})) begin
          ctr_s       = iv;
          remaining_s = nblocks;
          aes_in_s    = iv;
          wait_cnt_s  = 6'd0;
`ifdef CTR_LASTMASK_EN
          last_s      = last_bytes;
`endif
        end else begin
          ctr_s = ctr_r;
        end
      end
      S_KS_WAIT: begin
        if (wait_cnt_r == LAT_M1) begin
          ks_s       = aes_out;
          ct_ready_s = 1'b1;
        end else begin
          ks_s = ks_r;
        end
      end
      S_CT_WAIT: begin
        if (ct_valid && ct_ready) begin
`ifdef CTR_LASTMASK_EN
          pt_data_s = (remaining_r == ONE_BLK) ? ((ct_data ^ ks_r) & tail_mask(last_r))
                                               : (ct_data ^ ks_r);
`else
          pt_data_s = ct_data ^ ks_r;
`endif
          pt_valid_s = 1'b1;
          ct_ready_s = 1'b0;
          ctr_s      = ctr_r + 128'd1;
          aes_in_s   = ctr_r + 128'd1;
          wait_cnt_s = 6'd0;
        end else begin
          ct_ready_s = 1'b1;
        end
      end
      S_PT_OUT: begin
        if (pt_ready) begin
          pt_valid_s  = 1'b0;
          remaining_s = remaining_r - ONE_BLK;
        end else begin
          pt_valid_s = 1'b1;
        end
      end
      S_FINISH: ctr_s = ctr_r;
      default:  ctr_s = ctr_r;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ctr_r       <= 128'd0;
      ks_r        <= 128'd0;
      remaining_r <= {NB_W{1'b0}};
      wait_cnt_r  <= 6'd0;
      ct_ready    <= 1'b0;
      pt_valid    <= 1'b0;
      pt_data     <= 128'd0;
      aes_in      <= 128'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef CTR_LASTMASK_EN
      last_r      <= 4'd0;
`endif
    end else begin
      ctr_r       <= ctr_s;
      ks_r        <= ks_s;
      remaining_r <= remaining_s;
      wait_cnt_r  <= wait_cnt_s;
      ct_ready    <= ct_ready_s;
      pt_valid    <= pt_valid_s;
      pt_data     <= pt_data_s;
      aes_in      <= aes_in_s;
      busy        <= busy_s;
      done        <= done_s;
`ifdef CTR_LASTMASK_EN
      last_r      <= last_s;
`endif
    end
  end

endmodule

// File: tb/tb_ctr_decryption.sv
// Directed bench for ctr_decryption with a behavioural fixed-latency AES core and a plaintext scoreboard.
module tb_ctr_decryption;
  localparam int L = 15;

  localparam logic [255:0] KEY_V = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] IV_V  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] PT0 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] PT1 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] PT2 = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] PT3 = 128'hf69f2445df4f9b17ad2b417be66c3710;
  localparam logic [127:0] CT0 = 128'h601ec313775789a5b7a7f504bbf3d228;
  localparam logic [127:0] CT1 = 128'hf443e3ca4d62b59aca84e990cacaf5c5;
  localparam logic [127:0] CT2 = 128'h2b0930daa23de94ce87017ba2d84988d;
  localparam logic [127:0] CT3 = 128'hdfc9c58db67aada613c2dd08457941a6;
  localparam logic [127:0] KC  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [127:0] iv = 128'd0;
  logic [255:0] key = 256'd0;
  logic [3:0] nblocks = 4'd0;
  logic ct_valid = 1'b0, pt_ready = 1'b0;
  logic [127:0] ct_data = 128'd0;
  logic ct_ready, pt_valid, busy, done;
  logic [127:0] pt_data, aes_in, aes_out;
  logic [255:0] aes_key;
`ifdef CTR_LASTMASK_EN
  logic [3:0] last_bytes = 4'd0;
`endif

  int checks = 0;
  int errors = 0;
  logic [127:0] sb [$];
  logic [127:0] hist [0:L-2];

  ctr_decryption #(.AES_LATENCY(L), .MAX_BLOCKS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .iv(iv), .key(key), .nblocks(nblocks),
`ifdef CTR_LASTMASK_EN
    .last_bytes(last_bytes),
`endif
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
    .aes_in(aes_in), .aes_out(aes_out), .aes_key(aes_key),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Core model: known SP800-38A counters return the published keystream, others a fixed scramble.
  function automatic logic [127:0] core_f(input logic [127:0] x);
    case (x)
      IV_V:           core_f = PT0 ^ CT0;
      IV_V + 128'd1:  core_f = PT1 ^ CT1;
      IV_V + 128'd2:  core_f = PT2 ^ CT2;
      IV_V + 128'd3:  core_f = PT3 ^ CT3;
      default:        core_f = {x[63:0], x[127:64]} ^ KC;
    endcase
  endfunction

  // Output becomes valid during the L-th cycle after aes_in changes.
  always @(posedge clk) begin
    hist[0] <= aes_in;
    for (int i = 1; i < L - 1; i++) hist[i] <= hist[i-1];
  end
  assign aes_out = core_f(hist[L-2]);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ct_ready"}, {127'd0, ct_ready}, 128'd0);
    chk({tag, "_pt_valid"}, {127'd0, pt_valid}, 128'd0);
    chk({tag, "_pt_data"}, pt_data, 128'd0);
    chk({tag, "_aes_in"}, aes_in, 128'd0);
    chk({tag, "_busy"}, {127'd0, busy}, 128'd0);
    chk({tag, "_done"}, {127'd0, done}, 128'd0);
  endtask

  task automatic start_msg(input logic [127:0] v, input logic [3:0] n);
    iv = v;
    nblocks = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_ct(input logic [127:0] d, input logic [127:0] exp_pt);
    int n = 0;
    ct_data = d;
    ct_valid = 1'b1;
    sb.push_back(exp_pt);
    while (ct_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ct_accept", {127'd0, ct_ready}, 128'd1);
    @(negedge clk);
    ct_valid = 1'b0;
  endtask

  task automatic recv_pt(input string tag, input int stall);
    int n = 0;
    int bad = 0;
    logic [127:0] d;
    while (pt_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, {127'd0, pt_valid}, 128'd1);
    d = pt_data;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (pt_valid !== 1'b1 || pt_data !== d || ct_ready !== 1'b0) bad++;
    end
    if (stall > 0) chk({tag, "_hold"}, 128'(bad), 128'd0);
    pt_ready = 1'b1;
    @(negedge clk);
    pt_ready = 1'b0;
    chk({tag, "_drop"}, {127'd0, pt_valid}, 128'd0);
    chk({tag, "_sb_depth"}, 128'(sb.size()), 128'd1);
    if (sb.size() > 0) chk(tag, d, sb.pop_front());
  endtask

  task automatic chk_done(input string tag);
    chk({tag, "_done"}, {127'd0, done}, 128'd1);
    @(negedge clk);
    chk({tag, "_done_clr"}, {127'd0, done}, 128'd0);
    chk({tag, "_idle"}, {127'd0, busy}, 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    key = KEY_V;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("aes_key", aes_key[127:0] ^ aes_key[255:128], KEY_V[127:0] ^ KEY_V[255:128]);

    // SP800-38A F.5.6 vector
    start_msg(IV_V, 4'd4);
    chk("vec_aes_in", aes_in, IV_V);
    chk("vec_busy", {127'd0, busy}, 128'd1);
    send_ct(CT0, PT0); recv_pt("vec_b0", 0);
    send_ct(CT1, PT1); recv_pt("vec_b1", 0);
    send_ct(CT2, PT2); recv_pt("vec_b2", 0);
    send_ct(CT3, PT3); recv_pt("vec_b3", 0);
    chk_done("vec");

    // Counter wrap
    start_msg({128{1'b1}}, 4'd2);
    chk("wrap_aes_in0", aes_in, {128{1'b1}});
    send_ct(128'h00112233445566778899aabbccddeeff, 128'h00112233445566778899aabbccddeeff ^ core_f({128{1'b1}}));
    chk("wrap_aes_in1", aes_in, 128'd0);
    recv_pt("wrap_b0", 0);
    send_ct(128'hdeadbeef0badf00d1234567890abcdef, 128'hdeadbeef0badf00d1234567890abcdef ^ core_f(128'd0));
    recv_pt("wrap_b1", 0);
    chk_done("wrap");

    // Backpressure on the first block
    start_msg(128'h0000000000000000000000000000a000, 4'd2);
    send_ct(128'h55aa55aa55aa55aa55aa55aa55aa55aa, 128'h55aa55aa55aa55aa55aa55aa55aa55aa ^ core_f(128'ha000));
    recv_pt("bp_b0", 40);
    send_ct(128'h0123456789abcdeffedcba9876543210, 128'h0123456789abcdeffedcba9876543210 ^ core_f(128'ha001));
    recv_pt("bp_b1", 0);
    chk_done("bp");

    // Zero-length message
    start_msg(128'h1234, 4'd0);
    chk("nb0_done", {127'd0, done}, 128'd1);
    seen = (ct_ready === 1'b1) ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ct_ready === 1'b1) seen++;
      if (i == 0) chk("nb0_done_clr", {127'd0, done}, 128'd0);
    end
    chk("nb0_ct_ready", 128'(seen), 128'd0);

    // Reset during KS_WAIT of block 3
    start_msg(128'h0000000000000000000000000000b000, 4'd4);
    send_ct(128'h1111, 128'h1111 ^ core_f(128'hb000)); recv_pt("rst_b0", 0);
    send_ct(128'h2222, 128'h2222 ^ core_f(128'hb001)); recv_pt("rst_b1", 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midrst_idle", {127'd0, busy}, 128'd0);
    start_msg(IV_V, 4'd1);
    send_ct(CT0, PT0); recv_pt("post_rst", 0);
    chk_done("post_rst");

`ifdef CTR_LASTMASK_EN
    last_bytes = 4'd5;
    start_msg(IV_V, 4'd1);
    send_ct(CT0, PT0 & 128'hffffffffff0000000000000000000000);
    recv_pt("mask5", 0);
    chk_done("mask5");
    last_bytes = 4'd0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
